// File: rtl/prbs_checker.sv
// PRBS-10 (x^10 + x^3 + 1) stream checker.
// Seeds its history from the incoming stream, confirms LOCK_CNT predicted
// bits, then reports bit errors while locked. Lock is dropped on too many
// errors inside an ERR_WIN-bit window or on the all-zero lock-up pattern.
module prbs_checker #(
  parameter int LOCK_CNT = 16,
  parameter int ERR_WIN  = 32,
  parameter int ERR_LIM  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bit_valid,
  input  logic        bit_in,
  input  logic        clear,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_count,
  output logic [23:0] bit_count
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int WW = (ERR_WIN > 1) ? $clog2(ERR_WIN) : 1;
  localparam int EW = $clog2(ERR_LIM + 1);

  localparam logic [MW-1:0] MATCH_PRE = MW'(LOCK_CNT - 1);
  localparam logic [WW-1:0] WIN_LAST  = WW'(ERR_WIN - 1);
  localparam logic [EW-1:0] ERR_MAX   = EW'(ERR_LIM);

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [9:0]    hist, hist_n;
  logic [3:0]    seed_cnt, seed_cnt_n;
  logic [MW-1:0] match_cnt, match_cnt_n;
  logic [WW-1:0] win_cnt, win_cnt_n;
  logic [EW-1:0] win_err, win_err_n, win_err_sum;
  logic          err_pulse_n;
  logic [15:0]   err_count_n;
  logic [23:0]   bit_count_n;
  logic          mismatch;

  // State, history and counter registers; outputs are registered here too
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEED;
      hist      <= '0;
      seed_cnt  <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
      bit_count <= '0;
    end else begin
      state     <= state_n;
      hist      <= hist_n;
      seed_cnt  <= seed_cnt_n;
      match_cnt <= match_cnt_n;
      win_cnt   <= win_cnt_n;
      win_err   <= win_err_n;
      locked    <= (state_n == LOCKED);
      err_pulse <= err_pulse_n;
      err_count <= err_count_n;
      bit_count <= bit_count_n;
    end
  end

  // Next-state, history shift, error detection and counter updates
  always_comb begin
    state_n     = state;
    hist_n      = hist;
    seed_cnt_n  = seed_cnt;
    match_cnt_n = match_cnt;
    win_cnt_n   = win_cnt;
    win_err_n   = win_err;
    err_pulse_n = 1'b0;
    err_count_n = err_count;
    bit_count_n = bit_count;
    mismatch    = bit_in ^ (hist[9] ^ hist[2]);
    win_err_sum = win_err + EW'(mismatch);

    if (bit_valid) begin
      hist_n = {hist[8:0], bit_in};
      case (state)
        SEED: begin
          if (seed_cnt == 4'd9) begin
            state_n     = VERIFY;
            seed_cnt_n  = '0;
            match_cnt_n = '0;
          end else begin
            seed_cnt_n = seed_cnt + 4'd1;
          end
        end
        VERIFY: begin
          if (!mismatch && (hist != '0)) begin
            if (match_cnt == MATCH_PRE) begin
              state_n     = LOCKED;
              match_cnt_n = '0;
              win_cnt_n   = '0;
              win_err_n   = '0;
            end else begin
              match_cnt_n = match_cnt + MW'(1);
            end
          end else begin
            match_cnt_n = '0;
          end
        end
        LOCKED: begin
          if (bit_count != '1) bit_count_n = bit_count + 24'd1;
          if (mismatch) begin
            err_pulse_n = 1'b1;
            if (err_count != '1) err_count_n = err_count + 16'd1;
          end
          win_cnt_n = (win_cnt == WIN_LAST) ? '0 : win_cnt + WW'(1);
          // The limit test includes the error on the window's last bit
          // before the wrap clears the window count.
          if ((win_err_sum == ERR_MAX) || (hist_n == '0)) begin
            state_n    = SEED;
            seed_cnt_n = '0;
            win_err_n  = '0;
          end else begin
            win_err_n = (win_cnt == WIN_LAST) ? '0 : win_err_sum;
          end
        end
        default: state_n = SEED;
      endcase
    end

    if (clear) begin
      err_count_n = '0;
      bit_count_n = '0;
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: directed scenarios plus randomized traffic, all
// checked cycle by cycle against a bit-history reference model.
module tb_prbs_checker;

  localparam int LOCK_CNT = 16;
  localparam int ERR_WIN  = 32;
  localparam int ERR_LIM  = 4;

  logic        clk = 1'b0;
  logic        rst, bit_valid, bit_in, clear;
  logic        locked, err_pulse;
  logic [15:0] err_count;
  logic [23:0] bit_count;

  always #5 clk = ~clk;

  prbs_checker #(.LOCK_CNT(LOCK_CNT), .ERR_WIN(ERR_WIN), .ERR_LIM(ERR_LIM)) dut (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in), .clear(clear),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .bit_count(bit_count)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- stream generator (seed 10'h001) ----------------
  logic [9:0]  gseed = 10'h001;
  logic        gq[$];
  int unsigned gn = 0;

  task automatic gen_next(output logic b);
    if (gn < 10) b = gseed[9 - gn];
    else         b = gq[gq.size() - 10] ^ gq[gq.size() - 3];
    gq.push_back(b);
    if (gq.size() > 10) void'(gq.pop_front());
    gn++;
  endtask

  // ---------------- reference model ----------------
  typedef enum {PH_ACQ, PH_CONFIRM, PH_SYNC} phase_t;
  phase_t      m_phase;
  logic        rx[$];
  int unsigned m_seeded, m_run, m_since, m_werr, m_errc, m_bitc;
  logic        m_locked, m_pulse;

  function automatic logic past(int k);
    if (rx.size() < k) return 1'b0;
    return rx[rx.size() - k];
  endfunction

  function automatic logic last10_zero();
    for (int k = 1; k <= 10; k++) if (past(k)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(input logic v, input logic b, input logic c, input logic r);
    logic pred, was_zero;
    m_pulse = 1'b0;
    if (r) begin
      rx.delete();
      m_phase = PH_ACQ; m_seeded = 0; m_run = 0; m_since = 0; m_werr = 0;
      m_errc = 0; m_bitc = 0;
    end else begin
      if (v) begin
        pred     = past(10) ^ past(3);
        was_zero = last10_zero();
        rx.push_back(b);
        if (rx.size() > 10) void'(rx.pop_front());
        if (m_phase == PH_ACQ) begin
          m_seeded++;
          if (m_seeded == 10) begin m_phase = PH_CONFIRM; m_run = 0; end
        end else if (m_phase == PH_CONFIRM) begin
          if (b == pred && !was_zero) m_run++; else m_run = 0;
          if (m_run == LOCK_CNT) begin m_phase = PH_SYNC; m_since = 0; m_werr = 0; end
        end else begin
          if (m_bitc < 24'hFFFFFF) m_bitc++;
          if (b != pred) begin
            m_pulse = 1'b1;
            if (m_errc < 16'hFFFF) m_errc++;
            m_werr++;
          end
          m_since++;
          if (m_werr >= ERR_LIM || last10_zero()) begin
            m_phase = PH_ACQ; m_seeded = 0;
          end else if (m_since % ERR_WIN == 0) begin
            m_werr = 0;
          end
        end
      end
      if (c) begin m_errc = 0; m_bitc = 0; end
    end
    m_locked = (m_phase == PH_SYNC);
  endtask

  // One clock: drive inputs, advance model at the edge, compare after it
  task automatic step(input logic v, input logic b, input logic c, input logic r);
    bit_valid = v; bit_in = b; clear = c; rst = r;
    @(posedge clk);
    model_step(v, b, c, r);
    #1;
    check("locked",    32'(locked),    32'(m_locked));
    check("err_pulse", 32'(err_pulse), 32'(m_pulse));
    check("err_count", 32'(err_count), m_errc);
    check("bit_count", 32'(bit_count), m_bitc);
  endtask

  task automatic send(input int n);
    logic g;
    for (int i = 0; i < n; i++) begin
      gen_next(g);
      step(1'b1, g, 1'b0, 1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic g, v, c, r, b, inv, ever;
    int   first, drop_j, relock_j, errs;

    bit_valid = 1'b0; bit_in = 1'b0; clear = 1'b0; rst = 1'b1;

    // Reset state
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("reset_locked", 32'(locked), 32'd0);
    check("reset_errc",   32'(err_count), 32'd0);

    // Clean stream: lock visible right after the 26th bit
    first = 0;
    for (int i = 1; i <= 40; i++) begin
      gen_next(g);
      step(1'b1, g, 1'b0, 1'b0);
      if (first == 0 && locked === 1'b1) first = i;
    end
    check("lock_at_bit", first, 26);
    check("bitc_after_lock", 32'(bit_count), 32'd14);
    check("errc_clean", 32'(err_count), 32'd0);

    // One inverted bit: single-cycle pulse, lock kept; the bad bit also
    // corrupts the two later predictions that use it (3 errors total)
    gen_next(g);
    step(1'b1, ~g, 1'b0, 1'b0);
    check("pulse_on_err", 32'(err_pulse), 32'd1);
    check("errc_first",   32'(err_count), 32'd1);
    send(1);
    check("pulse_one_cycle", 32'(err_pulse), 32'd0);
    send(14);
    check("errc_after_prop", 32'(err_count), 32'd3);
    check("lock_kept_1err",  32'(locked), 32'd1);

    // Clear, align to a window start, then inject errors until lock drops
    gen_next(g);
    step(1'b1, g, 1'b1, 1'b0);
    for (int i = 0; i < ERR_WIN && (m_since % ERR_WIN) != 0; i++) send(1);
    drop_j = -1; relock_j = -1; errs = -1;
    for (int j = 0; j < 60; j++) begin
      gen_next(g);
      step(1'b1, g ^ logic'(j == 0 || j == 3), 1'b0, 1'b0);
      if (drop_j < 0 && locked === 1'b0) begin
        drop_j = j; errs = int'(err_count);
      end else if (drop_j >= 0 && relock_j < 0 && locked === 1'b1) begin
        relock_j = j;
      end
    end
    check("drop_bit",     drop_j, 13);
    check("errs_at_drop", errs, 4);
    check("relock_gap",   relock_j - drop_j, 26);

    // Clear coincident with an error: pulse still fires, counters zeroed
    send(2);
    gen_next(g);
    step(1'b1, ~g, 1'b1, 1'b0);
    check("clr_err_pulse", 32'(err_pulse), 32'd1);
    check("clr_err_errc",  32'(err_count), 32'd0);
    check("clr_err_bitc",  32'(bit_count), 32'd0);
    send(12);
    check("clr_err_after", 32'(err_count), 32'd2);

    // Reset mid-lock with err_count = 5, then clear while locked
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send(26);
    check("relock_after_rst", 32'(locked), 32'd1);
    for (int i = 0; i < ERR_WIN && (m_since % ERR_WIN) != 25; i++) send(1);
    for (int j = 0; j <= 30; j++) begin
      gen_next(g);
      step(1'b1, g ^ logic'(j == 0 || j == 7 || j == 14), 1'b0, 1'b0);
    end
    check("errc_five",   32'(err_count), 32'd5);
    check("lock_at_five", 32'(locked), 32'd1);
    gen_next(g);
    step(1'b1, g, 1'b0, 1'b1);
    check("rst_mid_locked", 32'(locked), 32'd0);
    check("rst_mid_errc",   32'(err_count), 32'd0);
    send(31);
    gen_next(g);
    step(1'b1, g, 1'b1, 1'b0);
    check("clear_keep_lock", 32'(locked), 32'd1);
    check("clear_bitc",      32'(bit_count), 32'd0);

    // All-zero stream never locks
    step(1'b0, 1'b0, 1'b0, 1'b1);
    ever = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      ever = ever | locked;
    end
    check("zero_never_lock", 32'(ever), 32'd0);

    // bit_valid toggling: 26 valid bits land on cycle 51
    step(1'b0, 1'b0, 1'b0, 1'b1);
    first = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      v = logic'(cyc % 2);
      if (v) gen_next(b); else b = 1'($urandom_range(1));
      step(v, b, 1'b0, 1'b0);
      if (first == 0 && locked === 1'b1) first = cyc;
    end
    check("toggle_lock_cycle", first, 51);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      v = logic'($urandom_range(3) != 0);
      r = logic'($urandom_range(511) == 0);
      c = logic'($urandom_range(127) == 0);
      if (v) begin
        gen_next(g);
        inv = logic'($urandom_range(63) == 0);
        b   = g ^ inv;
      end else begin
        b = 1'($urandom_range(1));
      end
      step(v, b, c, r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
